// File: rtl/mem_access.sv
// mem_access: MEM stage of the MIPS/DLX pipeline, producer side of write-back.
//
// Takes the EX/MEM instruction, runs a req/ack transaction on the data memory,
// extracts and extends load data (big-endian lanes), and registers the MEM/WB
// bundle (WB_control, reg_write, reg_dst, data_from_mem, data_from_ALU).
// stall holds EX/MEM and earlier stages while a memory access is outstanding.
//
// Ports:
//   clk, reset                  rising-edge clock, synchronous active-high reset
//   in_valid .. store_data      EX/MEM instruction fields
//   dmem_req/we/addr/be/wdata   memory request (held stable during ACCESS)
//   dmem_rdata, dmem_ack        memory response, ack is a one-cycle pulse
//   stall                       upstream hold
//   out_valid .. data_from_ALU  registered MEM/WB bundle
//   misaligned, bus_timeout     one-cycle fault pulses aligned with out_valid
//
// Optional feature: define ACCESS_TIMEOUT_EN to abort an access after
// TIMEOUT_CYCLES ACCESS cycles without ack. Undefined: ACCESS waits forever
// and bus_timeout stays 0.
module mem_access #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  mem_size,
    input  logic        load_unsigned,
    input  logic        WB_control_in,
    input  logic        reg_write_in,
    input  logic [4:0]  reg_dst_in,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        stall,
    output logic        out_valid,
    output logic        WB_control,
    output logic        reg_write,
    output logic [4:0]  reg_dst,
    output logic [31:0] data_from_mem,
    output logic [31:0] data_from_ALU,
    output logic        misaligned,
    output logic        bus_timeout
);

    typedef enum logic [0:0] {StIdle, StAccess} state_e;

    state_e      state_q, state_d;

    // Operation captured on entry to ACCESS
    logic [31:0] hold_addr_q, hold_addr_d;
    logic [31:0] hold_wdata_q, hold_wdata_d;
    logic [3:0]  hold_be_q, hold_be_d;
    logic [1:0]  hold_size_q, hold_size_d;
    logic [4:0]  hold_dst_q, hold_dst_d;
    logic        hold_we_q, hold_we_d;
    logic        hold_uns_q, hold_uns_d;
    logic        hold_wb_q, hold_wb_d;
    logic        hold_rw_q, hold_rw_d;

    // MEM/WB bundle
    logic        out_valid_q, out_valid_d;
    logic        wb_q, wb_d;
    logic        rw_q, rw_d;
    logic [4:0]  dst_q, dst_d;
    logic [31:0] mem_q, mem_d;
    logic [31:0] alu_q, alu_d;
    logic        mis_q, mis_d;
    logic        tmo_q, tmo_d;

    logic        mem_op, misalign, expire;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    assign mem_op   = mem_read | mem_write;
    // Reserved size 11 is treated as a word access
    assign misalign = (mem_size == 2'b01) ? alu_result[0] :
                      (mem_size[1] ? (alu_result[1:0] != 2'b00) : 1'b0);

`ifdef ACCESS_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CntW-1:0] tmo_cnt_q;

    always_ff @(posedge clk) begin
        if (reset || state_q != StAccess) begin
            tmo_cnt_q <= '0;
        end else if (!dmem_ack) begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
    end

    // Fires in the TIMEOUT_CYCLES-th ACCESS cycle without ack; ack wins
    assign expire = (state_q == StAccess) && !dmem_ack &&
                    (tmo_cnt_q == CntW'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
    assign expire = 1'b0;
`endif

    // Store lane steering, big-endian: address offset 00 is bits 31:24
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = store_data;
        case (mem_size)
            2'b00: begin
                st_be    = 4'b1000 >> alu_result[1:0];
                st_wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                st_be    = alu_result[1] ? 4'b0011 : 4'b1100;
                st_wdata = {2{store_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Load lane extraction and extension
    always_comb begin
        ld_byte = dmem_rdata[31:24];
        unique case (hold_addr_q[1:0])
            2'b00: ld_byte = dmem_rdata[31:24];
            2'b01: ld_byte = dmem_rdata[23:16];
            2'b10: ld_byte = dmem_rdata[15:8];
            2'b11: ld_byte = dmem_rdata[7:0];
        endcase
        ld_half = hold_addr_q[1] ? dmem_rdata[15:0] : dmem_rdata[31:16];
        case (hold_size_q)
            2'b00:   ld_ext = {{24{ld_byte[7] & ~hold_uns_q}}, ld_byte};
            2'b01:   ld_ext = {{16{ld_half[15] & ~hold_uns_q}}, ld_half};
            default: ld_ext = dmem_rdata;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        hold_addr_d  = hold_addr_q;
        hold_wdata_d = hold_wdata_q;
        hold_be_d    = hold_be_q;
        hold_size_d  = hold_size_q;
        hold_dst_d   = hold_dst_q;
        hold_we_d    = hold_we_q;
        hold_uns_d   = hold_uns_q;
        hold_wb_d    = hold_wb_q;
        hold_rw_d    = hold_rw_q;
        out_valid_d  = 1'b0;
        mis_d        = 1'b0;
        tmo_d        = 1'b0;
        wb_d         = wb_q;
        rw_d         = rw_q;
        dst_d        = dst_q;
        mem_d        = mem_q;
        alu_d        = alu_q;
        stall        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    if (!mem_op || misalign) begin
                        out_valid_d = 1'b1;
                        wb_d        = WB_control_in;
                        rw_d        = reg_write_in & ~mem_op;
                        dst_d       = reg_dst_in;
                        mem_d       = '0;
                        alu_d       = alu_result;
                        mis_d       = mem_op;
                    end else begin
                        stall        = 1'b1;
                        state_d      = StAccess;
                        hold_addr_d  = alu_result;
                        hold_wdata_d = st_wdata;
                        hold_be_d    = st_be;
                        hold_size_d  = mem_size;
                        hold_dst_d   = reg_dst_in;
                        hold_we_d    = mem_write;
                        hold_uns_d   = load_unsigned;
                        hold_wb_d    = WB_control_in;
                        hold_rw_d    = reg_write_in;
                    end
                end
            end
            StAccess: begin
                stall = ~(dmem_ack | expire);
                if (dmem_ack || expire) begin
                    state_d     = StIdle;
                    out_valid_d = 1'b1;
                    wb_d        = hold_wb_q;
                    rw_d        = hold_rw_q & ~expire;
                    dst_d       = hold_dst_q;
                    alu_d       = hold_addr_q;
                    mem_d       = (dmem_ack && !hold_we_q) ? ld_ext : 32'h0;
                    tmo_d       = expire;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            hold_addr_q  <= '0;
            hold_wdata_q <= '0;
            hold_be_q    <= '0;
            hold_size_q  <= '0;
            hold_dst_q   <= '0;
            hold_we_q    <= 1'b0;
            hold_uns_q   <= 1'b0;
            hold_wb_q    <= 1'b0;
            hold_rw_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            wb_q         <= 1'b0;
            rw_q         <= 1'b0;
            dst_q        <= '0;
            mem_q        <= '0;
            alu_q        <= '0;
            mis_q        <= 1'b0;
            tmo_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_addr_q  <= hold_addr_d;
            hold_wdata_q <= hold_wdata_d;
            hold_be_q    <= hold_be_d;
            hold_size_q  <= hold_size_d;
            hold_dst_q   <= hold_dst_d;
            hold_we_q    <= hold_we_d;
            hold_uns_q   <= hold_uns_d;
            hold_wb_q    <= hold_wb_d;
            hold_rw_q    <= hold_rw_d;
            out_valid_q  <= out_valid_d;
            wb_q         <= wb_d;
            rw_q         <= rw_d;
            dst_q        <= dst_d;
            mem_q        <= mem_d;
            alu_q        <= alu_d;
            mis_q        <= mis_d;
            tmo_q        <= tmo_d;
        end
    end

    assign dmem_req      = (state_q == StAccess);
    assign dmem_we       = dmem_req & hold_we_q;
    assign dmem_addr     = {hold_addr_q[31:2], 2'b00};
    assign dmem_be       = dmem_req ? hold_be_q : 4'b0000;
    assign dmem_wdata    = hold_wdata_q;
    assign out_valid     = out_valid_q;
    assign WB_control    = wb_q;
    assign reg_write     = rw_q;
    assign reg_dst       = dst_q;
    assign data_from_mem = mem_q;
    assign data_from_ALU = alu_q;
    assign misaligned    = mis_q;
    assign bus_timeout   = tmo_q;

endmodule
